// File: rtl/alu_mc_if.sv
// Opcode package and the issue/writeback handshake interface for alu_mc.
// Master drives operands and out_ready; slave (the ALU) drives results and in_ready.
package alu_mc_pkg;
    localparam logic [4:0] ALUOP_ADD = 5'd0;
    localparam logic [4:0] ALUOP_SUB = 5'd1;
    localparam logic [4:0] ALUOP_AND = 5'd2;
    localparam logic [4:0] ALUOP_OR  = 5'd3;
    localparam logic [4:0] ALUOP_XOR = 5'd4;
    localparam logic [4:0] ALUOP_NOR = 5'd5;
    localparam logic [4:0] ALUOP_SLT = 5'd6;
    localparam logic [4:0] ALUOP_SLL = 5'd7;
    localparam logic [4:0] ALUOP_SRL = 5'd8;
    localparam logic [4:0] ALUOP_SRA = 5'd9;
    localparam logic [4:0] ALUOP_BEQ = 5'd10;
    localparam logic [4:0] ALUOP_BNE = 5'd11;
    localparam logic [4:0] ALUOP_LUI = 5'd12;
    localparam logic [4:0] ALUOP_MOV = 5'd13;
    localparam logic [4:0] ALUOP_MUL = 5'd14;
    localparam logic [4:0] ALUOP_DIV = 5'd15;
endpackage

interface alu_mc_if #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    aluop;
    logic [N-1:0]  s;
    logic [N-1:0]  t;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out;
    logic [N-1:0]  hi;
    logic          zero;
    logic          overflow;

    modport master (
        output in_valid, aluop, s, t, shamt, out_ready,
        input  in_ready, out_valid, out, hi, zero, overflow
    );

    modport slave (
        input  in_valid, aluop, s, t, shamt, out_ready,
        output in_ready, out_valid, out, hi, zero, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on both sides. Define ALU_MULDIV_EN to build the
// iterative shift-add multiplier / restoring divider; otherwise MUL/DIV trap in one cycle.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic    clk,
    input  logic    reset,
    alu_mc_if.slave bus
);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t       state_reg, state_next;
    logic [N-1:0] out_reg, out_next;
    logic [N-1:0] hi_reg, hi_next;
    logic         zero_reg, zero_next;
    logic         ovf_reg, ovf_next;

    logic [SW-1:0] sh;
    logic [N-1:0]  sum, diff;
    logic [N-1:0]  simple_out, simple_hi;
    logic          simple_zero, simple_ovf;

    assign sh = bus.shamt;

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          is_div_reg, is_div_next;
    logic          neg_q_reg, neg_q_next;
    logic          neg_r_reg, neg_r_next;
    logic [N-1:0]  acc_reg, acc_next;
    logic [N-1:0]  q_reg, q_next;
    logic [N-1:0]  m_reg, m_next;

    logic          start_busy;
    logic [N-1:0]  s_mag, t_mag;
    logic [N:0]    mul_add, div_trial;
    logic [N-1:0]  acc_step, q_step;
    logic [2*N-1:0] prod_mag, prod_fix;
    logic [N-1:0]  quo_fix, rem_fix;
`endif

    // Single-cycle result, computed straight from the operands on the accept cycle.
    always_comb begin
        sum         = bus.s + bus.t;
        diff        = bus.s - bus.t;
        simple_out  = '0;
        simple_hi   = '0;
        simple_zero = 1'b0;
        simple_ovf  = 1'b0;
`ifdef ALU_MULDIV_EN
        start_busy  = 1'b0;
`endif
        case (bus.aluop)
            ALUOP_SLL: simple_out = bus.s << sh;
            ALUOP_SRL: simple_out = bus.s >> sh;
            ALUOP_SRA: simple_out = $signed(bus.s) >>> sh;
            ALUOP_ADD: begin
                simple_out = sum;
                simple_ovf = (bus.s[N-1] == bus.t[N-1]) && (sum[N-1] != bus.s[N-1]);
            end
            ALUOP_SUB: begin
                simple_out = diff;
                simple_ovf = (bus.s[N-1] != bus.t[N-1]) && (diff[N-1] != bus.s[N-1]);
            end
            ALUOP_AND: simple_out = bus.s & bus.t;
            ALUOP_OR:  simple_out = bus.s | bus.t;
            ALUOP_XOR: simple_out = bus.s ^ bus.t;
            ALUOP_NOR: simple_out = ~(bus.s | bus.t);
            ALUOP_SLT: simple_out = {{(N-1){1'b0}}, ($signed(bus.s) < $signed(bus.t))};
            ALUOP_BEQ: simple_zero = (bus.s == bus.t);
            ALUOP_BNE: simple_zero = (bus.s != bus.t);
            ALUOP_LUI: simple_out = {bus.t[N/2-1:0], {(N/2){1'b0}}};
            ALUOP_MOV: simple_out = bus.s;
`ifdef ALU_MULDIV_EN
            ALUOP_MUL: start_busy = 1'b1;
            ALUOP_DIV: begin
                if (bus.t == '0) begin
                    simple_hi  = bus.s;
                    simple_ovf = 1'b1;
                end else if ((bus.s == MIN_VAL) && (bus.t == '1)) begin
                    simple_out = MIN_VAL;
                    simple_ovf = 1'b1;
                end else begin
                    start_busy = 1'b1;
                end
            end
`else
            ALUOP_MUL: simple_ovf = 1'b1;
            ALUOP_DIV: simple_ovf = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Both iterations work on magnitudes; signs are reapplied on the final step.
    always_comb begin
        s_mag     = bus.s[N-1] ? -bus.s : bus.s;
        t_mag     = bus.t[N-1] ? -bus.t : bus.t;
        mul_add   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : {(N+1){1'b0}});
        div_trial = {acc_reg, q_reg[N-1]} - {1'b0, m_reg};
        if (is_div_reg) begin
            if (!div_trial[N]) begin
                acc_step = div_trial[N-1:0];
                q_step   = {q_reg[N-2:0], 1'b1};
            end else begin
                acc_step = {acc_reg[N-2:0], q_reg[N-1]};
                q_step   = {q_reg[N-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_add[N:1];
            q_step   = {mul_add[0], q_reg[N-1:1]};
        end
        prod_mag = {acc_step, q_step};
        prod_fix = neg_q_reg ? -prod_mag : prod_mag;
        quo_fix  = neg_q_reg ? -q_step : q_step;
        rem_fix  = neg_r_reg ? -acc_step : acc_step;
    end
`endif

    always_comb begin
        state_next  = state_reg;
        out_next    = out_reg;
        hi_next     = hi_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
`ifdef ALU_MULDIV_EN
        cnt_next    = cnt_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        acc_next    = acc_reg;
        q_next      = q_reg;
        m_next      = m_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (start_busy) begin
                        state_next  = BUSY;
                        cnt_next    = CW'(N);
                        is_div_next = (bus.aluop == ALUOP_DIV);
                        neg_q_next  = bus.s[N-1] ^ bus.t[N-1];
                        neg_r_next  = bus.s[N-1];
                        acc_next    = '0;
                        q_next      = (bus.aluop == ALUOP_DIV) ? s_mag : t_mag;
                        m_next      = (bus.aluop == ALUOP_DIV) ? t_mag : s_mag;
                    end else
`endif
                    begin
                        state_next = DONE;
                        out_next   = simple_out;
                        hi_next    = simple_hi;
                        zero_next  = simple_zero;
                        ovf_next   = simple_ovf;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                cnt_next = cnt_reg - 1'b1;
                acc_next = acc_step;
                q_next   = q_step;
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                    zero_next  = 1'b0;
                    if (is_div_reg) begin
                        out_next = quo_fix;
                        hi_next  = rem_fix;
                        ovf_next = 1'b0;
                    end else begin
                        out_next = prod_fix[N-1:0];
                        hi_next  = prod_fix[2*N-1:N];
                        ovf_next = (prod_fix[2*N-1:N] != {N{prod_fix[N-1]}});
                    end
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            out_reg    <= '0;
            hi_reg     <= '0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
`ifdef ALU_MULDIV_EN
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            acc_reg    <= '0;
            q_reg      <= '0;
            m_reg      <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            hi_reg     <= hi_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
`ifdef ALU_MULDIV_EN
            cnt_reg    <= cnt_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            acc_reg    <= acc_next;
            q_reg      <= q_next;
            m_reg      <= m_next;
`endif
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out       = out_reg;
    assign bus.hi        = hi_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (N=32); MUL/DIV expectations follow ALU_MULDIV_EN.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mc_if #(.N(32)) bus ();
    alu_mc #(.N(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [31:0] r_out, r_hi;
    logic        r_zero, r_ovf;
    int          r_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for the result, optionally hold it, then release it.
    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold);
        @(negedge clk);
        check({name, ":in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1; bus.aluop = op; bus.s = a; bus.t = b; bus.shamt = sh;
        bus.out_ready = 1'b0;
        @(posedge clk);
        r_lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.s = ~a; bus.t = ~b; bus.shamt = ~sh;
        while (!bus.out_valid && r_lat < 100) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
        end
        r_out = bus.out; r_hi = bus.hi; r_zero = bus.zero; r_ovf = bus.overflow;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.aluop = ALUOP_OR; bus.s = '1; bus.t = '1;
            @(negedge clk);
            check({name, ":hold_out"}, 64'(bus.out), 64'(r_out));
            check({name, ":hold_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.aluop = ALUOP_OR;
        @(negedge clk);
        check({name, ":released"}, 64'(bus.out_valid), 64'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        $display("op %-10s s=%08h t=%08h sh=%0d lat=%0d out=%08h hi=%08h zero=%0b ovf=%0b",
                 name, a, b, sh, r_lat, r_out, r_hi, r_zero, r_ovf);
    endtask

    task automatic expect_op(input string name, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh, input int lat,
                             input logic [31:0] eout, input logic [31:0] ehi,
                             input logic ezero, input logic eovf);
        run_op(name, op, a, b, sh, 0);
        check({name, ":lat"}, 64'(r_lat), 64'(lat));
        check({name, ":out"}, 64'(r_out), 64'(eout));
        check({name, ":hi"}, 64'(r_hi), 64'(ehi));
        check({name, ":zero"}, 64'(r_zero), 64'(ezero));
        check({name, ":ovf"}, 64'(r_ovf), 64'(eovf));
    endtask

    initial begin
        int vcnt;
        bus.in_valid = 1'b0; bus.aluop = '0; bus.s = '0; bus.t = '0; bus.shamt = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:in_ready", 64'(bus.in_ready), 64'd1);
        check("rst:out_valid", 64'(bus.out_valid), 64'd0);
        check("rst:out", 64'(bus.out), 64'd0);
        check("rst:hi", 64'(bus.hi), 64'd0);
        check("rst:flags", 64'({bus.zero, bus.overflow}), 64'd0);
        reset = 1'b0;
        $display("op reset     released");

        run_op("add_ovf", ALUOP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 3);
        check("add_ovf:lat", 64'(r_lat), 64'd1);
        check("add_ovf:out", 64'(r_out), 64'h8000_0000);
        check("add_ovf:ovf", 64'(r_ovf), 64'd1);
        check("add_ovf:hi", 64'(r_hi), 64'd0);

        expect_op("sub", ALUOP_SUB, 32'd5, 32'd7, 5'd0, 1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);
        expect_op("sub_ovf", ALUOP_SUB, 32'h8000_0000, 32'd1, 5'd0, 1, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
        expect_op("beq", ALUOP_BEQ, 32'd5, 32'd5, 5'd0, 1, 32'h0, 32'h0, 1'b1, 1'b0);
        expect_op("bne", ALUOP_BNE, 32'd5, 32'd5, 5'd0, 1, 32'h0, 32'h0, 1'b0, 1'b0);
        expect_op("slt", ALUOP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 32'h1, 32'h0, 1'b0, 1'b0);
        expect_op("slt_n", ALUOP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 1, 32'h0, 32'h0, 1'b0, 1'b0);
        expect_op("sra", ALUOP_SRA, 32'h8000_0000, 32'h0, 5'd4, 1, 32'hF800_0000, 32'h0, 1'b0, 1'b0);
        expect_op("srl", ALUOP_SRL, 32'h8000_0000, 32'h0, 5'd4, 1, 32'h0800_0000, 32'h0, 1'b0, 1'b0);
        expect_op("sll", ALUOP_SLL, 32'h1, 32'h0, 5'd31, 1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        expect_op("lui", ALUOP_LUI, 32'h0, 32'h1234_ABCD, 5'd0, 1, 32'hABCD_0000, 32'h0, 1'b0, 1'b0);
        expect_op("mov", ALUOP_MOV, 32'hDEAD_BEEF, 32'h1, 5'd0, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        expect_op("nor", ALUOP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd0, 1, 32'hF0F0_FF00, 32'h0, 1'b0, 1'b0);
        expect_op("xor", ALUOP_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 1, 32'hF0F0_F0F0, 32'h0, 1'b0, 1'b0);
        expect_op("undef", 5'd31, 32'h1234_5678, 32'h1, 5'd3, 1, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef ALU_MULDIV_EN
        expect_op("mul_neg", ALUOP_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 33, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expect_op("mul_big", ALUOP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 33, 32'h0, 32'h1, 1'b0, 1'b1);
        expect_op("div_neg", ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expect_op("div_negt", ALUOP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0, 33, 32'hFFFF_FFFD, 32'h1, 1'b0, 1'b0);
        expect_op("div_zero", ALUOP_DIV, 32'h0000_1234, 32'h0, 5'd0, 1, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
        expect_op("div_min", ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
`else
        expect_op("mul_trap", ALUOP_MUL, 32'd2, 32'd3, 5'd0, 1, 32'h0, 32'h0, 1'b0, 1'b1);
        expect_op("div_trap", ALUOP_DIV, 32'd6, 32'd3, 5'd0, 1, 32'h0, 32'h0, 1'b0, 1'b1);
`endif

        // out_ready held high: the result is visible for one cycle only.
        @(negedge clk);
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.aluop = ALUOP_SUB;
        bus.s = 32'd9; bus.t = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid) begin
                vcnt++;
                check("cont:out", 64'(bus.out), 64'd5);
            end
            @(negedge clk);
        end
        check("cont:valid_cycles", 64'(vcnt), 64'd1);
        bus.out_ready = 1'b0;
        $display("op cont_rdy  valid_cycles=%0d", vcnt);

        // Reset in the middle of a long (or pending) operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
`ifdef ALU_MULDIV_EN
        bus.aluop = ALUOP_MUL;
`else
        bus.aluop = ALUOP_ADD;
`endif
        bus.s = 32'hFFFF_FFFD; bus.t = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst:in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst:out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst:out", 64'(bus.out), 64'd0);
        check("mid_rst:hi", 64'(bus.hi), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        check("mid_rst:discarded", 64'(vcnt), 64'd0);
        $display("op mid_reset discarded_valid_cycles=%0d", vcnt);

        expect_op("and", ALUOP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1, 32'hF000_F000, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
